cacheline_mem_arbiter: RTL and testbench

Shares the single burst-memory port (cacheline adaptor side, `mem_*`) between the instruction-cache and data-cache miss paths of the mp4 pipeline. Each cache issues whole-line reads (dcache also line writebacks). The block grants one requester at a time, holds that grant for the whole transaction, forwards the memory response to the winner only, and returns to idle for at least one cycle before the next grant. It sits between the two caches and the cacheline adaptor.

---
 rtl/cacheline_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_cacheline_mem_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_mem_arbiter.sv
// cacheline_mem_arbiter: shares one burst-memory port between the icache and
// dcache miss paths. One requester is granted at a time and keeps the grant
// until the adaptor answers; the arbiter then idles for at least one cycle.
// Optional feature macro: ARB_RR_EN (round-robin on simultaneous requests;
// when undefined, dcache has fixed priority over icache).
module cacheline_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_I    = 2'd1,
    GRANT_D_RD = 2'd2,
    GRANT_D_WR = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                d_req;
  logic                d_pref;

`ifdef ARB_RR_EN
  // pref_d_q = 1 means dcache wins the next tie; reset favours icache.
  logic                pref_d_q, pref_d_d;
  assign d_pref = pref_d_q;
`else
  logic                pref_unused;
  assign d_pref      = 1'b1;
  assign pref_unused = 1'b0;
`endif

  assign d_req = d_read | d_write;

  // Next-state logic: arbitrate and capture the winner's command in IDLE,
  // hold everything steady during a grant, leave on the adaptor's response.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef ARB_RR_EN
    pref_d_d = pref_d_q;
`endif
    case (state_q)
      IDLE: begin
        if (d_req && (!i_read || d_pref)) begin
          addr_d = d_addr;
          if (d_write) begin
            state_d = GRANT_D_WR;
            wdata_d = d_wdata;
          end else begin
            state_d = GRANT_D_RD;
          end
`ifdef ARB_RR_EN
          pref_d_d = 1'b0;
`endif
        end else if (i_read) begin
          state_d = GRANT_I;
          addr_d  = i_addr;
`ifdef ARB_RR_EN
          pref_d_d = 1'b1;
`endif
        end
      end
      GRANT_I, GRANT_D_RD, GRANT_D_WR: begin
        if (mem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured command registers; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef ARB_RR_EN
  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (!rst) pref_d_q <= 1'b0;
    else      pref_d_q <= pref_d_d;
  end
`endif

  assign mem_read  = (state_q == GRANT_I) || (state_q == GRANT_D_RD);
  assign mem_write = (state_q == GRANT_D_WR);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Response goes only to the granted side, in the same cycle as mem_resp.
  assign i_resp  = (state_q == GRANT_I) && mem_resp;
  assign d_resp  = ((state_q == GRANT_D_RD) || (state_q == GRANT_D_WR)) && mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Testbench for cacheline_mem_arbiter: directed scenarios followed by random
// traffic, checked every cycle against a transaction-level reference model.
module tb_cacheline_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read, d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;

  always #5 clk = ~clk;

  cacheline_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  int ncmp = 0;
  int nfail = 0;

  // Reference model: owner of the memory port (-1 none, 0 icache read,
  // 1 dcache read, 2 dcache write) plus the command captured at grant time.
  int            m_own;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  bit            pref_i;
  int            cnt, lat, lat_fix;
  bit            lat_rand, rand_fill;
  logic [LW-1:0] fill;
  bit            got_i, got_d;
  int            n_iresp, n_dresp;
  int            q_order[$];

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive the adaptor, check outputs mid-cycle, advance model.
  task automatic cyc();
    bit d_wins;
    if (rand_fill)
      for (int k = 0; k < LW / 32; k++) fill[k*32 +: 32] = $urandom;
    mem_rdata = fill;
    mem_resp  = (m_own >= 0) && (cnt >= lat);
    #4;
    chk("mem_read",  mem_read,  (m_own == 0 || m_own == 1));
    chk("mem_write", mem_write, (m_own == 2));
    chk("mem_addr",  mem_addr,  m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("i_resp",    i_resp,    (m_own == 0) && mem_resp);
    chk("d_resp",    d_resp,    (m_own > 0) && mem_resp);
    chk("i_rdata",   i_rdata,   mem_rdata);
    chk("d_rdata",   d_rdata,   mem_rdata);
    got_i = (m_own == 0) && mem_resp;
    got_d = (m_own > 0) && mem_resp;
    if (got_i) begin n_iresp++; q_order.push_back(0); end
    if (got_d) begin n_dresp++; q_order.push_back(1); end
    if (!rst) begin
      m_own = -1; m_addr = '0; m_wdata = '0; pref_i = 1'b1;
    end else if (m_own < 0) begin
`ifdef ARB_RR_EN
      d_wins = (d_read || d_write) && (!i_read || !pref_i);
`else
      d_wins = d_read || d_write;
`endif
      cnt = 0;
      lat = lat_rand ? $urandom_range(0, 4) : lat_fix;
      if (d_wins) begin
        m_own  = d_write ? 2 : 1;
        m_addr = d_addr;
        if (d_write) m_wdata = d_wdata;
        pref_i = 1'b1;
      end else if (i_read) begin
        m_own  = 0;
        m_addr = i_addr;
        pref_i = 1'b0;
      end
    end else if (mem_resp) begin
      m_own = -1;
    end else begin
      cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_order[4];
    int r;
    rst = 1'b0; i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    m_own = -1; m_addr = '0; m_wdata = '0; pref_i = 1'b1;
    cnt = 0; lat = 0; lat_fix = 2; lat_rand = 1'b0; rand_fill = 1'b1; fill = '0;
    n_iresp = 0; n_dresp = 0;
    @(posedge clk);
    #1;
    // Reset state held for two cycles
    cyc(); cyc();

    // Lone icache read, 5-cycle adaptor latency, A5 fill
    rst = 1'b1; rand_fill = 1'b0;
    for (int k = 0; k < LW / 8; k++) fill[k*8 +: 8] = 8'hA5;
    lat_fix = 5; i_addr = 32'h0000_0060; i_read = 1'b1;
    n_iresp = 0; n_dresp = 0;
    for (int k = 0; k < 20 && !got_i; k++) cyc();
    i_read = 1'b0;
    cyc();
    chk("t1_iresp_count", n_iresp, 1);
    chk("t1_dresp_count", n_dresp, 0);

    // Lone dcache writeback with address changed mid-grant
    rand_fill = 1'b1; lat_fix = 4; n_iresp = 0; n_dresp = 0;
    d_addr = 32'h0000_1000; d_write = 1'b1;
    d_wdata = 256'h123456789ABCDEF0_0FEDCBA987654321_1122334455667788_99AABBCCDDEEFF00;
    for (int k = 0; k < 20 && !got_d; k++) begin
      if (k == 2) begin d_addr = 32'hDEAD_0000; d_wdata = '1; end
      cyc();
    end
    d_write = 1'b0;
    cyc(); cyc();
    chk("t2_dresp_count", n_dresp, 1);
    chk("t2_iresp_count", n_iresp, 0);

    // Simultaneous icache and dcache reads
    q_order.delete(); lat_fix = 2;
    i_addr = 32'h0000_0080; d_addr = 32'h0000_0100;
    i_read = 1'b1; d_read = 1'b1;
    for (int k = 0; k < 30 && (i_read || d_read); k++) begin
      cyc();
      if (got_i) i_read = 1'b0;
      if (got_d) d_read = 1'b0;
    end
    cyc();
    chk("t3_resp_total", q_order.size(), 2);
    if (q_order.size() == 2) begin
`ifdef ARB_RR_EN
      chk("t3_first", q_order[0], 0);
      chk("t3_second", q_order[1], 1);
`else
      chk("t3_first", q_order[0], 1);
      chk("t3_second", q_order[1], 0);
`endif
    end

    // Both caches request continuously right after reset
    rst = 1'b0; cyc(); rst = 1'b1;
    q_order.delete(); lat_fix = 1;
    i_read = 1'b1; d_read = 1'b1;
    for (int k = 0; k < 60 && q_order.size() < 4; k++) cyc();
    i_read = 1'b0; d_read = 1'b0;
    cyc();
`ifdef ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{1, 1, 1, 1};
`endif
    chk("t4_resp_total", q_order.size(), 4);
    for (int k = 0; k < 4 && k < q_order.size(); k++)
      chk($sformatf("t4_order%0d", k), q_order[k], exp_order[k]);

    // Reset during a dcache read grant, request held through reset
    n_dresp = 0; lat_fix = 8;
    d_addr = 32'h0000_0200; d_read = 1'b1;
    cyc(); cyc(); cyc();
    rst = 1'b0; cyc();
    rst = 1'b1;
    chk("t5_dresp_after_rst", n_dresp, 0);
    for (int k = 0; k < 20 && !got_d; k++) cyc();
    d_read = 1'b0;
    cyc();
    chk("t5_dresp_count", n_dresp, 1);

    // Read and write both high counts as a write
    lat_fix = 1; n_dresp = 0;
    d_addr = 32'h0000_0040; d_wdata = 256'hCAFE; d_read = 1'b1; d_write = 1'b1;
    cyc();
    chk("t6_mem_write", mem_write, 1'b1);
    chk("t6_mem_read", mem_read, 1'b0);
    for (int k = 0; k < 20 && !got_d; k++) cyc();
    d_read = 1'b0; d_write = 1'b0;
    cyc();
    chk("t6_dresp_count", n_dresp, 1);

    // Random traffic with random adaptor latency and occasional reset
    lat_rand = 1'b1;
    for (int k = 0; k < 600; k++) begin
      cyc();
      rst = ($urandom_range(0, 99) != 0);
      if (got_i) i_read = 1'b0;
      if (!i_read && $urandom_range(0, 2) == 0) begin
        i_read = 1'b1; i_addr = $urandom;
      end
      if (got_d) begin d_read = 1'b0; d_write = 1'b0; end
      if (!d_read && !d_write && $urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 2);
        d_read = (r != 1); d_write = (r != 0);
        d_addr = $urandom;
        for (int j = 0; j < LW / 32; j++) d_wdata[j*32 +: 32] = $urandom;
      end else if ((d_read || d_write) && $urandom_range(0, 7) == 0) begin
        d_addr = $urandom;
      end
      if (i_read && $urandom_range(0, 7) == 0) i_addr = $urandom;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
